// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared state encoding and default NOP for the handshaked pipeline stage register.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: width-parametrised saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: IF/ID-style valid/ready stage with a 2-entry skid buffer, stall and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int unsigned         INSTR_W  = 32,
    parameter int unsigned         PC_W     = 32,
    parameter logic [INSTR_W-1:0]  NOP_WORD = INSTR_W'(NOP_DEFAULT),
    parameter int unsigned         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_stall_cnt,
    output logic [CNT_W-1:0]   perf_bubble_cnt
`endif
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    main_pc4_q, main_pc4_d, skid_pc4_q, skid_pc4_d;
    logic               in_ready_q, in_ready_d;
    logic               accept, drain;

    assign accept = in_valid & in_ready_q & ~flush;
    assign drain  = out_valid & out_ready & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_WORD;
            main_pc4_q   <= '0;
            skid_instr_q <= NOP_WORD;
            skid_pc4_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc4_q   <= main_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc4_d   = main_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = NOP_WORD;
            main_pc4_d   = '0;
            skid_instr_d = NOP_WORD;
            skid_pc4_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    state_d      = ST_FULL;
                    main_instr_d = in_instr;
                    main_pc4_d   = in_pc4;
                end
                ST_FULL: if (accept && drain) begin
                    main_instr_d = in_instr;
                    main_pc4_d   = in_pc4;
                end else if (accept) begin
                    state_d      = ST_SKID;
                    skid_instr_d = in_instr;
                    skid_pc4_d   = in_pc4;
                end else if (drain) begin
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_WORD;
                    main_pc4_d   = '0;
                end
                // in_ready is low here, so the skid entry only ever moves forward
                ST_SKID: if (drain) begin
                    state_d      = ST_FULL;
                    main_instr_d = skid_instr_q;
                    main_pc4_d   = skid_pc4_q;
                    skid_instr_d = NOP_WORD;
                    skid_pc4_d   = '0;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_SKID);
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q != ST_EMPTY);
        out_instr = out_valid ? main_instr_q : NOP_WORD;
        out_pc4   = out_valid ? main_pc4_q : '0;
    end

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (out_valid & stall),
        .cnt_o (perf_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i ((~out_valid & ~stall) | flush),
        .cnt_o (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc4, out_instr, out_pc4;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] perf_stall_cnt, perf_bubble_cnt;
`endif

    pipe_stage_reg #(
        .INSTR_W  (32),
        .PC_W     (32),
        .NOP_WORD (32'h0),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   m_stall_cnt, m_bubble_cnt;
    int   total = 0, bad = 0;

    function automatic logic [65:0] exp_vec();
        if (q.size() == 0) return {m_ready, 1'b0, 64'h0};
        return {m_ready, 1'b1, q[0].instr, q[0].pc4};
    endfunction

    function automatic logic [65:0] dut_vec();
        return {in_ready, out_valid, out_instr, out_pc4};
    endfunction

    function automatic int sat_inc(int v, bit inc);
        return (inc && v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_ready      = 1'b1;
        m_stall_cnt  = 0;
        m_bubble_cnt = 0;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc4    = 32'h0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic step();
        bit ov, acc, drn;
        ent_t e;
        ov  = q.size() > 0;
        acc = in_valid && m_ready && !flush;
        drn = ov && out_ready && !stall;
        e.instr = in_instr;
        e.pc4   = in_pc4;
        m_stall_cnt  = sat_inc(m_stall_cnt, ov && stall);
        m_bubble_cnt = sat_inc(m_bubble_cnt, (!ov && !stall) || flush);
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        m_ready = q.size() < 2;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc4 = 32'h40;
        step();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_preload out_valid got=%b exp=1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (dut_vec() !== {1'b1, 1'b0, 64'h0}) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), {1'b1, 1'b0, 64'h0});
        end
        #2;
        reset = 1'b0;
        model_clear();
        idle_inputs();
        step();
        total++;
        if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_streaming();
        logic [31:0] ins[2];
        logic [31:0] pcs[2];
        ins[0] = 32'h2009_0005; ins[1] = 32'h012A_5820;
        pcs[0] = 32'h04;        pcs[1] = 32'h08;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc4 = pcs[i];
            step();
            total++;
            if (dut_vec() !== {1'b1, 1'b1, ins[i], pcs[i]}) begin
                bad++; $display("FAIL stream_%0d got=%h exp=%h", i, dut_vec(), {1'b1, 1'b1, ins[i], pcs[i]});
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (dut_vec() !== {1'b1, 1'b0, 64'h0}) begin
            bad++; $display("FAIL stream_drained got=%h exp=%h", dut_vec(), {1'b1, 1'b0, 64'h0});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins[3];
        logic [31:0] seen[$];
        ins[0] = 32'h1111_0001; ins[1] = 32'h2222_0002; ins[2] = 32'h3333_0003;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc4 = 32'(4 * (i + 1));
            step();
        end
        total++;
        if ({in_ready, out_valid, out_instr} !== {1'b0, 1'b1, ins[0]}) begin
            bad++; $display("FAIL bp_full got ready=%b valid=%b instr=%h exp ready=0 valid=1 instr=%h",
                            in_ready, out_valid, out_instr, ins[0]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen.push_back(out_instr);
            step();
            if (in_ready && in_instr == ins[2] && in_valid && q.size() > 0 && q[q.size()-1].instr == ins[2])
                in_valid = 1'b0;
            total++;
            if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL bp_drain_%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
        end
        total++;
        if (seen.size() != 3 || seen[0] !== ins[0] || seen[1] !== ins[1] || seen[2] !== ins[2]) begin
            bad++; $display("FAIL bp_order got count=%0d exp count=3", seen.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = 32'h8C08_0010;
        do_reset();
        in_valid = 1'b1; in_instr = held; in_pc4 = 32'h0000_0010;
        step();
        in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if ({out_valid, out_instr, out_pc4} !== {1'b1, held, 32'h10}) begin
                bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", c, {out_valid, out_instr, out_pc4}, {1'b1, held, 32'h10});
            end
        end
`ifdef PIPE_STAGE_PERF_EN
        total++;
        if (perf_stall_cnt !== CW'(4)) begin bad++; $display("FAIL perf_stall got=%0d exp=4", perf_stall_cnt); end
`endif
        stall = 1'b0;
        step();
        total++;
        if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL stall_release got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_flush();
        logic [31:0] squashed;
        squashed = 32'h0800_BEEF;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = 32'hA000_0000 + 32'(i); in_pc4 = 32'(8 * i);
            step();
        end
        in_valid = 1'b1; in_instr = squashed; in_pc4 = 32'h100; flush = 1'b1; stall = 1'b1;
        step();
        total++;
        if (dut_vec() !== {1'b1, 1'b0, 64'h0}) begin
            bad++; $display("FAIL flush_skid got=%h exp=%h", dut_vec(), {1'b1, 1'b0, 64'h0});
        end
        in_valid = 1'b0; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || out_instr === squashed) begin
                bad++; $display("FAIL flush_after_%0d got valid=%b instr=%h exp valid=0", c, out_valid, out_instr);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 20; c++) step();
`ifdef PIPE_STAGE_PERF_EN
        total++;
        if (perf_bubble_cnt !== CW'(15)) begin bad++; $display("FAIL perf_bubble_sat got=%0d exp=15", perf_bubble_cnt); end
`endif
        total++;
        if (dut_vec() !== {1'b1, 1'b0, 64'h0}) begin bad++; $display("FAIL idle_state got=%h", dut_vec()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = $urandom_range(0, 99) < 70;
            in_instr  = $urandom;
            in_pc4    = $urandom;
            out_ready = $urandom_range(0, 99) < 65;
            stall     = $urandom_range(0, 99) < 20;
            flush     = $urandom_range(0, 99) < 5;
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rand_%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
`ifdef PIPE_STAGE_PERF_EN
            total++;
            if ({perf_stall_cnt, perf_bubble_cnt} !== {CW'(m_stall_cnt), CW'(m_bubble_cnt)}) begin
                bad++; $display("FAIL rand_perf_%0d got=%0d/%0d exp=%0d/%0d", c,
                                perf_stall_cnt, perf_bubble_cnt, m_stall_cnt, m_bubble_cnt);
            end
`endif
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_clear();
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
